// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - 2x2 stride-2 streaming max pool over a raster conv result stream
// Optional fused ReLU on the pooled output when MAXPOOL_RELU_EN is defined.
module maxpool2x2_stream #(
  parameter int IH  = 26,
  parameter int IW  = 26,
  parameter int AW  = 10,
  parameter int OAW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic signed [7:0]     in_data,
  input  logic [AW-1:0]         in_addr,
  output logic                  out_valid,
  output logic signed [7:0]     out_data,
  output logic [OAW-1:0]        out_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  seq_err
);

  localparam int RW = (IH > 1) ? $clog2(IH) : 1;
  localparam int CW = (IW > 1) ? $clog2(IW) : 1;
  localparam int BW = (CW > 1) ? CW - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic signed [7:0]     hmax;
  logic signed [7:0]     pbuf [2**BW];
  logic                  accept, last_in, done_nxt;
  logic [BW-1:0]         bidx;
  logic [AW-1:0]         exp_addr;
  logic signed [7:0]     pair_max, pooled, pooled_out;

  function automatic logic signed [7:0] smax(input logic signed [7:0] a, input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // A start pulse takes priority and swallows any sample presented alongside it.
  assign accept   = (state == S_RUN) && in_valid && !start;
  assign last_in  = (row == RW'(IH - 1)) && (col == CW'(IW - 1));
  assign bidx     = BW'(col >> 1);
  assign exp_addr = AW'(row) * AW'(IW) + AW'(col);
  assign pair_max = smax(hmax, in_data);
  assign pooled   = smax(pbuf[bidx], pair_max);

`ifdef MAXPOOL_RELU_EN
  assign pooled_out = pooled[7] ? 8'sd0 : pooled;
`else
  assign pooled_out = pooled;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_RUN:   if (accept && last_in) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == S_RUN);
    done_nxt = (state == S_DONE) && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      hmax    <= '0;
      seq_err <= 1'b0;
    end else if (start) begin
      row     <= '0;
      col     <= '0;
      hmax    <= '0;
      seq_err <= 1'b0;
    end else if (accept) begin
      if (in_addr != exp_addr) seq_err <= 1'b1;
      if (!col[0]) hmax <= in_data;
      if (col == CW'(IW - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Even rows write the buffer and odd rows read it, so the same entry is never hit twice in a cycle.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) pbuf[bidx] <= pair_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= done_nxt;
      if (accept && col[0] && row[0]) begin
        out_valid <= 1'b1;
        out_data  <= pooled_out;
        out_addr  <= OAW'(row >> 1) * OAW'(IW / 2) + OAW'(col >> 1);
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - directed self-checking bench for maxpool2x2_stream
// Three instances: 4x4 (u=0), 26x26 (u=1), 5x5 (u=2).
module tb_maxpool2x2_stream;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        st, vl;
  logic signed [7:0] in_data;
  logic [9:0]        in_addr;
  logic [2:0]        ov, bsy, dn, serr;
  logic signed [7:0] od_w [3];
  logic [7:0]        oa_w [3];

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                ov_cnt [3];
  int                dn_cnt [3];
  int                ov_cyc [3];
  int                dn_cyc [3];
  logic signed [7:0] od [3][512];
  int                oa [3][512];

  always #5 clk = ~clk;

  maxpool2x2_stream #(.IH(4), .IW(4), .AW(10), .OAW(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(vl[0]), .in_data(in_data), .in_addr(in_addr),
    .out_valid(ov[0]), .out_data(od_w[0]), .out_addr(oa_w[0]), .busy(bsy[0]), .done(dn[0]), .seq_err(serr[0]));

  maxpool2x2_stream #(.IH(26), .IW(26), .AW(10), .OAW(8)) u26 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(vl[1]), .in_data(in_data), .in_addr(in_addr),
    .out_valid(ov[1]), .out_data(od_w[1]), .out_addr(oa_w[1]), .busy(bsy[1]), .done(dn[1]), .seq_err(serr[1]));

  maxpool2x2_stream #(.IH(5), .IW(5), .AW(10), .OAW(8)) u5 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(vl[2]), .in_data(in_data), .in_addr(in_addr),
    .out_valid(ov[2]), .out_data(od_w[2]), .out_addr(oa_w[2]), .busy(bsy[2]), .done(dn[2]), .seq_err(serr[2]));

  initial begin
    for (int u = 0; u < 3; u++) begin
      ov_cnt[u] = 0; dn_cnt[u] = 0; ov_cyc[u] = 0; dn_cyc[u] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 3; u++) begin
      if (ov[u] === 1'b1 && ov_cnt[u] < 512) begin
        od[u][ov_cnt[u]] = od_w[u];
        oa[u][ov_cnt[u]] = int'(oa_w[u]);
        ov_cnt[u]++;
        ov_cyc[u] = cyc;
      end
      if (dn[u] === 1'b1) begin
        dn_cnt[u]++;
        dn_cyc[u] = cyc;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input int d, input int a);
    in_data = 8'(d);
    in_addr = 10'(a);
    vl[u]   = 1'b1;
    tick(1);
    vl[u]   = 1'b0;
  endtask

  task automatic pulse_start(input int u);
    st[u] = 1'b1;
    tick(1);
    st[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input int base, input string tag);
    int n = 0;
    while (dn_cnt[u] == base && n < 100) begin
      tick(1);
      n++;
    end
    tick(3);
    chk(tag, dn_cnt[u] - base, 1);
  endtask

  task automatic chk_out(input int u, input int idx, input int d, input int a, input string tag);
    chk({tag, "_data"}, int'(od[u][idx]), d);
    chk({tag, "_addr"}, oa[u][idx], a);
  endtask

  int base, dbase, nbad, exp_v;
  logic signed [7:0] t3 [16];

  initial begin
    rst_n = 1'b0; st = '0; vl = '0; in_data = '0; in_addr = '0;
    tick(3);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_out_data", int'(od_w[0]), 0);
    chk("rst_out_addr", int'(oa_w[0]), 0);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_seq_err", int'(serr[0]), 0);
    rst_n = 1'b1;
    tick(1);

    // in_valid while IDLE is ignored
    send(0, 50, 3);
    send(0, 60, 9);
    tick(3);
    chk("idle_no_out", ov_cnt[0], 0);
    chk("idle_no_err", int'(serr[0]), 0);

    // T1
    base = ov_cnt[0]; dbase = dn_cnt[0];
    pulse_start(0);
    chk("t1_busy", int'(bsy[0]), 1);
    for (int k = 0; k < 16; k++) send(0, k, k);
    wait_done(0, dbase, "t1_done_cnt");
    chk("t1_out_cnt", ov_cnt[0] - base, 4);
    chk_out(0, base + 0, 5, 0, "t1_o0");
    chk_out(0, base + 1, 7, 1, "t1_o1");
    chk_out(0, base + 2, 13, 2, "t1_o2");
    chk_out(0, base + 3, 15, 3, "t1_o3");
    chk("t1_done_lat", dn_cyc[0] - ov_cyc[0], 1);
    chk("t1_busy_end", int'(bsy[0]), 0);
    chk("t1_seq_err", int'(serr[0]), 0);

    // T2
    base = ov_cnt[1]; dbase = dn_cnt[1];
    pulse_start(1);
    for (int k = 0; k < 676; k++) send(1, -5, k);
    wait_done(1, dbase, "t2_done_cnt");
    chk("t2_out_cnt", ov_cnt[1] - base, 169);
`ifdef MAXPOOL_RELU_EN
    exp_v = 0;
`else
    exp_v = -5;
`endif
    nbad = 0;
    for (int i = 0; i < 169; i++)
      if (int'(od[1][base + i]) != exp_v || oa[1][base + i] != i) nbad++;
    chk("t2_bad_outputs", nbad, 0);
    chk("t2_seq_err", int'(serr[1]), 0);

    // T3
    t3 = '{-128, 127, -1, 0,
           -1, 0, 127, -128,
           0, -1, -128, 127,
           127, -128, 0, -1};
    base = ov_cnt[0]; dbase = dn_cnt[0];
    pulse_start(0);
    for (int k = 0; k < 16; k++) send(0, int'(t3[k]), k);
    wait_done(0, dbase, "t3_done_cnt");
    chk("t3_out_cnt", ov_cnt[0] - base, 4);
    for (int i = 0; i < 4; i++) chk_out(0, base + i, 127, i, "t3_o");

    // T4
    base = ov_cnt[0]; dbase = dn_cnt[0];
    pulse_start(0);
    for (int k = 0; k < 6; k++) send(0, k, k);
    chk("t4_err_before", int'(serr[0]), 0);
    for (int k = 6; k < 16; k++) send(0, k, k + 1);
    chk("t4_err_set", int'(serr[0]), 1);
    wait_done(0, dbase, "t4_done_cnt");
    chk("t4_err_sticky", int'(serr[0]), 1);
    chk("t4_out_cnt", ov_cnt[0] - base, 4);
    chk_out(0, base + 0, 5, 0, "t4_o0");
    chk_out(0, base + 3, 15, 3, "t4_o3");
    pulse_start(0);
    chk("t4_err_cleared", int'(serr[0]), 0);

    // T5: restart mid-frame; the sample presented with start is dropped
    base = ov_cnt[0];
    for (int k = 0; k < 9; k++) send(0, k, k);
    chk("t5_old_out_cnt", ov_cnt[0] - base, 2);
    base = ov_cnt[0]; dbase = dn_cnt[0];
    st[0] = 1'b1; vl[0] = 1'b1; in_data = 8'sd99; in_addr = 10'd9;
    tick(1);
    st[0] = 1'b0; vl[0] = 1'b0;
    for (int k = 0; k < 16; k++) send(0, 20 + k, k);
    wait_done(0, dbase, "t5_done_cnt");
    chk("t5_out_cnt", ov_cnt[0] - base, 4);
    chk_out(0, base + 0, 25, 0, "t5_o0");
    chk_out(0, base + 1, 27, 1, "t5_o1");
    chk_out(0, base + 2, 33, 2, "t5_o2");
    chk_out(0, base + 3, 35, 3, "t5_o3");
    chk("t5_seq_err", int'(serr[0]), 0);

    // T6: reset mid-frame, right as a pooled output is being presented
    pulse_start(2);
    for (int k = 0; k < 7; k++) begin
      send(2, 90 + k, k);
      if (k % 2 == 0 && k != 6) tick(1);
    end
    chk("t6_ov_before_rst", int'(ov[2]), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ov", int'(ov[2]), 0);
    chk("t6_rst_data", int'(od_w[2]), 0);
    chk("t6_rst_addr", int'(oa_w[2]), 0);
    chk("t6_rst_busy", int'(bsy[2]), 0);
    base = ov_cnt[2];
    tick(2);
    chk("t6_rst_no_out", ov_cnt[2] - base, 0);
    rst_n = 1'b1;
    tick(1);
    chk("t6_idle_busy", int'(bsy[2]), 0);
    base = ov_cnt[2]; dbase = dn_cnt[2];
    pulse_start(2);
    for (int k = 0; k < 25; k++) begin
      send(2, k, k);
      if (k % 7 == 3) tick(1);
    end
    wait_done(2, dbase, "t6_done_cnt");
    chk("t6_out_cnt", ov_cnt[2] - base, 4);
    chk_out(2, base + 0, 6, 0, "t6_o0");
    chk_out(2, base + 1, 8, 1, "t6_o1");
    chk_out(2, base + 2, 16, 2, "t6_o2");
    chk_out(2, base + 3, 18, 3, "t6_o3");
    chk("t6_seq_err", int'(serr[2]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
